// File: rtl/uart_pkg.sv
// Shared UART receiver types, parity encodings and sampling constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int         TICKS_PER_BIT = 8;
    localparam logic [2:0] TICK_LAST     = 3'(TICKS_PER_BIT - 1);
    localparam logic [2:0] VOTE_FIRST    = 3'd3;
    localparam logic [2:0] VOTE_LAST     = 3'd5;

    function automatic logic [3:0] clamp_bits(
        input logic [3:0] bits,
        input logic [3:0] max_bits
    );
        if (bits < 4'd5)
            return 4'd5;
        else if (bits > max_bits)
            return max_bits;
        else
            return bits;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous receive FIFO with occupancy count; a pop frees room
// for a same-cycle push when full.
module uart_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [DW-1:0]           i_data,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [DW-1:0]           o_data,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = r_count[AW];
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + PTR_ONE;
            if (w_pop)
                r_rd <= r_rd + PTR_ONE;
            if (w_push && !w_pop)
                r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (8 ticks/bit, 3-sample vote) feeding an
// AXI-Stream FIFO. Define UART_RX_PARITY_EN to enable parity checking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic [3:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          break_detect
);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    rx_state_t       r_state;
    logic [15:0]     r_div;
    logic [2:0]      r_tidx;
    logic [1:0]      r_ones;
    logic [3:0]      r_bidx;
    logic [3:0]      r_nbits;
    logic            r_stop2;
    logic            r_stop_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic            r_zero;
    logic            r_ferr;
    logic            r_brk_wait;
    logic            r_brk_p;
    logic            r_ferr_p;
    logic            r_ovr_p;

    logic [15:0]     w_period;
    logic            w_start;
    logic            w_tick;
    logic            w_vote;
    logic            w_bit_end;
    logic            w_bit;
    logic [DATA_WIDTH-1:0] w_mask;
    logic            w_last;
    logic            w_brk;
    logic            w_ferr;
    logic            w_perr;
    logic            w_push;
    logic            w_full;
    logic            w_empty;

`ifdef UART_RX_PARITY_EN
    logic [1:0]      r_pmode;
    logic            r_par;
    logic            r_perr;
    logic            r_perr_p;
    logic            w_par_en;

    assign w_par_en     = (r_pmode == PAR_EVEN) || (r_pmode == PAR_ODD);
    assign w_perr       = w_last && !w_brk && !w_ferr && r_perr;
    assign parity_error = r_perr_p;
`else
    logic            w_unused_par;

    assign w_unused_par = (parity_mode == PAR_EVEN) |
                          (parity_mode == PAR_ODD) |
                          (parity_mode == PAR_NONE);
    assign w_perr       = 1'b0;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Tick divider restarts on the start edge so sampling is edge-aligned
    assign w_period  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_start   = (r_state == S_IDLE) && !r_brk_wait &&
                       r_rx_prev && !r_sync2;
    assign w_tick    = (r_state != S_IDLE) && (r_div == 16'd0);
    assign w_vote    = w_tick && (r_tidx >= VOTE_FIRST) &&
                       (r_tidx <= VOTE_LAST);
    assign w_bit_end = w_tick && (r_tidx == TICK_LAST);
    assign w_bit     = (r_ones >= 2'd2);
    assign w_mask    = {{(DATA_WIDTH-1){1'b0}}, w_bit} << r_bidx;

    assign w_last = (r_state == S_STOP) && w_bit_end &&
                    (!r_stop2 || r_stop_idx);
    assign w_brk  = w_last && r_zero && !w_bit;
    assign w_ferr = w_last && !w_brk && (r_ferr || !w_bit);
    assign w_push = w_last && !w_brk && !w_ferr && !w_perr;

    always_ff @(posedge clk) begin
        if (rst)
            r_div <= '0;
        else if (w_start || w_tick)
            r_div <= w_period - 16'd1;
        else if (r_div != 16'd0)
            r_div <= r_div - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tidx     <= '0;
            r_ones     <= '0;
            r_bidx     <= '0;
            r_nbits    <= 4'd5;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_zero     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk_wait <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pmode    <= PAR_NONE;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            if (w_tick)
                r_tidx <= r_tidx + 3'd1;
            if (w_vote && r_sync2)
                r_ones <= r_ones + 2'd1;
            if (w_bit_end)
                r_ones <= '0;
            if (r_sync2)
                r_brk_wait <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_start) begin
                    r_state    <= S_START;
                    r_tidx     <= '0;
                    r_ones     <= '0;
                    r_bidx     <= '0;
                    r_shift    <= '0;
                    r_zero     <= 1'b1;
                    r_ferr     <= 1'b0;
                    r_stop_idx <= 1'b0;
                    r_nbits    <= clamp_bits(data_bits, 4'(DATA_WIDTH));
                    r_stop2    <= stop_bits;
`ifdef UART_RX_PARITY_EN
                    r_pmode    <= parity_mode;
                    r_par      <= 1'b0;
                    r_perr     <= 1'b0;
`endif
                end
                S_START: if (w_bit_end)
                    r_state <= w_bit ? S_IDLE : S_DATA;
                S_DATA: if (w_bit_end) begin
                    r_shift <= r_shift | w_mask;
                    r_zero  <= r_zero & ~w_bit;
                    r_bidx  <= r_bidx + 4'd1;
`ifdef UART_RX_PARITY_EN
                    r_par   <= r_par ^ w_bit;
                    if (r_bidx == r_nbits - 4'd1)
                        r_state <= w_par_en ? S_PARITY : S_STOP;
`else
                    if (r_bidx == r_nbits - 4'd1)
                        r_state <= S_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (w_bit_end) begin
                    r_zero  <= r_zero & ~w_bit;
                    r_perr  <= (r_par ^ w_bit) != (r_pmode == PAR_ODD);
                    r_state <= S_STOP;
                end
`endif
                S_STOP: if (w_bit_end) begin
                    r_zero     <= r_zero & ~w_bit;
                    r_ferr     <= r_ferr | ~w_bit;
                    r_stop_idx <= 1'b1;
                    if (w_last)
                        r_state <= S_IDLE;
                    if (w_brk)
                        r_brk_wait <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk_p  <= 1'b0;
            r_ferr_p <= 1'b0;
            r_ovr_p  <= 1'b0;
        end else begin
            r_brk_p  <= w_brk;
            r_ferr_p <= w_ferr;
            r_ovr_p  <= w_push && w_full && !m_axis_tready;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_perr_p <= 1'b0;
        else
            r_perr_p <= w_perr;
    end
`endif

    uart_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (m_axis_tready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (m_axis_tdata),
        .o_count (fifo_count)
    );

    assign m_axis_tvalid = !w_empty;
    assign busy          = (r_state != S_IDLE);
    assign overrun_error = r_ovr_p;
    assign frame_error   = r_ferr_p;
    assign break_detect  = r_brk_p;

endmodule
